instruction_mem_sync: RTL and testbench
=======================================

# instruction_mem_sync

Parametrised, synchronous instruction memory that replaces the combinational 16-bit instruction ROM in the fetch path. It accepts one fetch request at a time over a valid/ready handshake and returns the instruction after a configurable number of cycles. It flags misaligned and out-of-range fetches and supports pipeline flush. A write port loads the program image at run time.

## Interface
- ADDR_WIDTH, 16, width of the byte address on req_addr and wr_addr
- DATA_WIDTH, 16, instruction width; each word occupies 2 bytes of address space
- DEPTH, 256, number of instruction words (word index 0..DEPTH-1)
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15
- FILL_WORD, 16'h0000, value stored at power-up and returned on a fault
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request present
- req_ready  output  1  block can accept a request this cycle
- req_addr  input  ADDR_WIDTH  byte address of the instruction
- flush  input  1  abandon any outstanding fetch
- rsp_valid  output  1  one-cycle pulse; rsp_instr and rsp_fault are valid
- rsp_instr  output  DATA_WIDTH  fetched instruction
- rsp_fault  output  1  request was misaligned or out of range
- wr_en  input  1  program-load write strobe
- wr_addr  input  ADDR_WIDTH  byte address to write
- wr_data  input  DATA_WIDTH  word to write

## Operation
- Word index is addr[ADDR_WIDTH-1:1].
- A request is misaligned when addr[0]=1.
- A request is out of range when its index is DEPTH or greater.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting; req_ready=0.
  - RESP: rsp_valid=1; req_ready=1.
- Acceptance happens at an edge where req_valid && req_ready && !flush.
  - req_ready is combinationally forced to 0 while flush=1.
- On acceptance:
  - Read the array at the word index and latch the data.
  - Latch the fault as (misaligned || out of range).
  - Load the wait counter with LATENCY-1.
  - Go to RESP if LATENCY=1; otherwise go to WAIT.
- WAIT decrements the counter each cycle and moves to RESP when it reaches 0.
- RESP lasts exactly one cycle.
  - If a new request is accepted in that cycle, go to WAIT or RESP per LATENCY.
  - Otherwise go to IDLE.
- On a fault, rsp_instr=FILL_WORD and rsp_fault=1. Fault responses take the same latency as normal ones.
- No response back-pressure: the consumer must take rsp_valid when it is asserted.
- Flush:
  - In WAIT or RESP: go to IDLE next cycle; the pending response is never delivered.
  - If flush is high during the RESP cycle, rsp_valid is forced to 0 combinationally.
- Writes:
  - When wr_en=1, the addressed word is written at the edge, in any state.
  - Misaligned or out-of-range writes are ignored.
- Array contents initialise to FILL_WORD at time zero. rst does not clear the array.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_instr=FILL_WORD, rsp_fault=0, counter=0.
- rst mid-operation drops any outstanding fetch with no response. rst has priority over flush and acceptance.
- Request accepted at edge E0: rsp_valid is high in the cycle following edge E0+LATENCY-1.
- Sustained throughput: one fetch per LATENCY cycles, since a new request may be accepted during RESP.
- Read data is sampled at the acceptance edge.
  - A write to the same word at the acceptance edge returns the old data.
  - A write during WAIT does not change the pending response.
- rsp_instr and rsp_fault hold their last value outside RESP. Only rsp_valid qualifies them.

## Test plan
- Load mem[0x00]=16'h1234 and mem[0x0D]=16'hABCD with LATENCY=2. Fetch addr 16'h0000, then 16'h001A. Each rsp_valid pulse arrives 2 cycles after acceptance with 16'h1234 and 16'hABCD, and rsp_fault=0.
- Fetch 16'hFFFF (misaligned) and 16'h0200 (index 256 = DEPTH). Both give rsp_fault=1 and rsp_instr=16'h0000 after LATENCY cycles.
- With LATENCY=1, drive back-to-back requests 0x0, 0x2, 0x4, ... Each is accepted in the RESP cycle of its predecessor: one response every cycle after the first, in address order.
- Accept a request, then assert flush in the next cycle (LATENCY=3). No rsp_valid occurs for it. req_ready returns to 1 the cycle after flush. A following fetch of 16'h0002 returns its stored word normally.
- In the acceptance cycle, write 16'h5555 to the same address that held 16'hAAAA. The response is 16'hAAAA; a second fetch of that address returns 16'h5555.
- Assert rst during WAIT. No rsp_valid follows. All outputs take their reset values one edge later. Memory contents are preserved, checked by refetching a written word.

Source files
------------

// File: rtl/instruction_mem_sync_if.sv
// Fetch-side bus of the synchronous instruction memory: request/response
// handshake, pipeline flush and the program-load write port.
interface instruction_mem_sync_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  flush;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic                  rsp_fault;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output req_valid, req_addr, flush, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/instruction_mem_sync.sv
// Synchronous instruction memory: one outstanding fetch, fixed response
// latency, fault flagging for misaligned/out-of-range fetches, and flush.
module instruction_mem_sync #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 256,
  parameter int                    LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 16'h0000
) (
  input logic                    clk,
  input logic                    rst,
  instruction_mem_sync_if.slave  bus
);

  localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Word-aligned and inside the array: shared by the fetch and write ports.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[0] == 1'b0) && ({1'b0, addr[ADDR_WIDTH-1:1]} < DEPTH_W);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: FILL_WORD};

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pend_instr_q, pend_instr_d;
  logic                  pend_fault_q, pend_fault_d;
  logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic                  rsp_fault_q, rsp_fault_d;

  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_ok;
  logic                  req_ready;
  logic                  accept;

  // Address decode, array read and handshake qualification.
  always_comb begin
    rd_ok     = addr_ok(bus.req_addr);
    wr_ok     = bus.wr_en && addr_ok(bus.wr_addr);
    req_ready = (state_q != S_WAIT) && !bus.flush;
    accept    = bus.req_valid && req_ready;
    if (rd_ok) begin
      rd_word = mem_q[bus.req_addr[IDX_W:1]];
    end else begin
      rd_word = FILL_WORD;
    end
  end

  // Next-state logic; the response registers only load on entry to RESP so
  // they keep their last delivered value everywhere else.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_instr_d = pend_instr_q;
    pend_fault_d = pend_fault_q;
    rsp_instr_d  = rsp_instr_q;
    rsp_fault_d  = rsp_fault_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_WAIT: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d     = S_RESP;
          cnt_d       = 4'd0;
          rsp_instr_d = pend_instr_q;
          rsp_fault_d = pend_fault_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Acceptance is only possible in IDLE or RESP and overrides the above.
    if (accept) begin
      pend_instr_d = rd_word;
      pend_fault_d = !rd_ok;
      cnt_d        = LAT_M1;
      if (LATENCY == 1) begin
        state_d     = S_RESP;
        rsp_instr_d = rd_word;
        rsp_fault_d = !rd_ok;
      end else begin
        state_d = S_WAIT;
      end
    end else begin
      pend_instr_d = pend_instr_d;
    end
  end

  // Control and response registers; reset wins over flush and acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      pend_instr_q <= FILL_WORD;
      pend_fault_q <= 1'b0;
      rsp_instr_q  <= FILL_WORD;
      rsp_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_instr_q <= pend_instr_d;
      pend_fault_q <= pend_fault_d;
      rsp_instr_q  <= rsp_instr_d;
      rsp_fault_q  <= rsp_fault_d;
    end
  end

  // Program-load port; the array is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[bus.wr_addr[IDX_W:1]] <= bus.wr_data;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == S_RESP) && !bus.flush;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instruction_mem_sync.sv
// Directed bench: three instances at LATENCY 1, 2 and 3 share clock and reset.
module tb_instruction_mem_sync;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instruction_mem_sync_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if1 ();
  instruction_mem_sync_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if2 ();
  instruction_mem_sync_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if3 ();

  instruction_mem_sync #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .LATENCY(1),
                         .FILL_WORD(16'h0000)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
  instruction_mem_sync #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .LATENCY(2),
                         .FILL_WORD(16'h0000)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
  instruction_mem_sync #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .LATENCY(3),
                         .FILL_WORD(16'h0000)) u_l3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if1.req_valid = 1'b0; if1.req_addr = 16'h0000; if1.flush = 1'b0;
    if1.wr_en = 1'b0; if1.wr_addr = 16'h0000; if1.wr_data = 16'h0000;
    if2.req_valid = 1'b0; if2.req_addr = 16'h0000; if2.flush = 1'b0;
    if2.wr_en = 1'b0; if2.wr_addr = 16'h0000; if2.wr_data = 16'h0000;
    if3.req_valid = 1'b0; if3.req_addr = 16'h0000; if3.flush = 1'b0;
    if3.wr_en = 1'b0; if3.wr_addr = 16'h0000; if3.wr_data = 16'h0000;
  endtask

  task automatic wr_all(input logic [15:0] addr, input logic [15:0] data);
    if1.wr_en = 1'b1; if1.wr_addr = addr; if1.wr_data = data;
    if2.wr_en = 1'b1; if2.wr_addr = addr; if2.wr_data = data;
    if3.wr_en = 1'b1; if3.wr_addr = addr; if3.wr_data = data;
    step();
    if1.wr_en = 1'b0; if2.wr_en = 1'b0; if3.wr_en = 1'b0;
  endtask

  // Complete fetch on the LATENCY=2 instance: response one cycle after WAIT.
  task automatic fetch_l2(input logic [15:0] addr, input logic [15:0] exp_instr,
                          input logic exp_fault);
    if2.req_valid = 1'b1;
    if2.req_addr  = addr;
    #1;
    chk1("l2_accept_ready", if2.req_ready, 1'b1);
    step();
    if2.req_valid = 1'b0;
    #1;
    chk1("l2_wait_valid", if2.rsp_valid, 1'b0);
    chk1("l2_wait_ready", if2.req_ready, 1'b0);
    step();
    #1;
    chk1("l2_resp_valid", if2.rsp_valid, 1'b1);
    chk16("l2_resp_instr", if2.rsp_instr, exp_instr);
    chk1("l2_resp_fault", if2.rsp_fault, exp_fault);
    step();
    #1;
    chk1("l2_after_valid", if2.rsp_valid, 1'b0);
    chk16("l2_hold_instr", if2.rsp_instr, exp_instr);
  endtask

  initial begin
    logic [15:0] l1_exp [4];
    l1_exp[0] = 16'h1234; l1_exp[1] = 16'h1111;
    l1_exp[2] = 16'h2222; l1_exp[3] = 16'h3333;

    rst = 1'b1;
    idle_all();
    step();
    step();
    chk1("rst_ready", if2.req_ready, 1'b1);
    chk1("rst_valid", if2.rsp_valid, 1'b0);
    chk16("rst_instr", if2.rsp_instr, 16'h0000);
    chk1("rst_fault", if2.rsp_fault, 1'b0);
    rst = 1'b0;

    // Program image, then illegal writes that would alias onto words 0 and 1.
    wr_all(16'h0000, 16'h1234);
    wr_all(16'h001A, 16'hABCD);
    wr_all(16'h0002, 16'h1111);
    wr_all(16'h0004, 16'h2222);
    wr_all(16'h0006, 16'h3333);
    wr_all(16'h0010, 16'hAAAA);
    wr_all(16'h01FE, 16'h7777);
    wr_all(16'h0200, 16'hDEAD);
    wr_all(16'h0003, 16'hDEAD);

    // LATENCY=2 normal, last-word and fault fetches.
    fetch_l2(16'h0000, 16'h1234, 1'b0);
    fetch_l2(16'h001A, 16'hABCD, 1'b0);
    fetch_l2(16'hFFFF, 16'h0000, 1'b1);
    fetch_l2(16'h01FE, 16'h7777, 1'b0);
    fetch_l2(16'h0200, 16'h0000, 1'b1);

    // LATENCY=1 back-to-back: each request accepted in its predecessor's RESP.
    if1.req_valid = 1'b1;
    if1.req_addr  = 16'h0000;
    #1;
    chk1("l1_first_ready", if1.req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        if1.req_addr = 16'(2 * (i + 1));
      end else begin
        if1.req_valid = 1'b0;
      end
      #1;
      chk1("l1_b2b_valid", if1.rsp_valid, 1'b1);
      chk16("l1_b2b_instr", if1.rsp_instr, l1_exp[i]);
      chk1("l1_b2b_ready", if1.req_ready, 1'b1);
    end
    step();
    #1;
    chk1("l1_end_valid", if1.rsp_valid, 1'b0);
    chk16("l1_end_hold", if1.rsp_instr, 16'h3333);

    // LATENCY=3 flush during WAIT: the response is never delivered.
    if3.req_valid = 1'b1;
    if3.req_addr  = 16'h001A;
    step();
    if3.req_valid = 1'b0;
    if3.flush     = 1'b1;
    #1;
    chk1("l3_flush_ready", if3.req_ready, 1'b0);
    chk1("l3_flush_valid", if3.rsp_valid, 1'b0);
    step();
    if3.flush = 1'b0;
    #1;
    chk1("l3_post_flush_ready", if3.req_ready, 1'b1);
    chk1("l3_post_flush_valid", if3.rsp_valid, 1'b0);
    step();
    #1;
    chk1("l3_no_resp_a", if3.rsp_valid, 1'b0);
    step();
    #1;
    chk1("l3_no_resp_b", if3.rsp_valid, 1'b0);
    chk16("l3_no_resp_instr", if3.rsp_instr, 16'h0000);

    // LATENCY=3 normal fetch after the flush (also proves the 0x0003 write was dropped).
    if3.req_valid = 1'b1;
    if3.req_addr  = 16'h0002;
    step();
    if3.req_valid = 1'b0;
    #1;
    chk1("l3_wait1_valid", if3.rsp_valid, 1'b0);
    step();
    #1;
    chk1("l3_wait2_valid", if3.rsp_valid, 1'b0);
    step();
    #1;
    chk1("l3_resp_valid", if3.rsp_valid, 1'b1);
    chk16("l3_resp_instr", if3.rsp_instr, 16'h1111);
    chk1("l3_resp_fault", if3.rsp_fault, 1'b0);
    step();
    #1;
    chk1("l3_after_valid", if3.rsp_valid, 1'b0);

    // LATENCY=3 flush in the RESP cycle masks rsp_valid immediately.
    if3.req_valid = 1'b1;
    if3.req_addr  = 16'h001A;
    step();
    if3.req_valid = 1'b0;
    step();
    step();
    if3.flush = 1'b1;
    #1;
    chk1("l3_resp_flush_valid", if3.rsp_valid, 1'b0);
    chk1("l3_resp_flush_ready", if3.req_ready, 1'b0);
    step();
    if3.flush = 1'b0;
    #1;
    chk1("l3_resp_flush_idle_ready", if3.req_ready, 1'b1);
    chk1("l3_resp_flush_idle_valid", if3.rsp_valid, 1'b0);

    // Write at the acceptance edge returns the old word.
    if2.req_valid = 1'b1;
    if2.req_addr  = 16'h0010;
    if2.wr_en     = 1'b1;
    if2.wr_addr   = 16'h0010;
    if2.wr_data   = 16'h5555;
    step();
    if2.req_valid = 1'b0;
    if2.wr_en     = 1'b0;
    #1;
    chk1("raw_wait_valid", if2.rsp_valid, 1'b0);
    step();
    #1;
    chk1("raw_resp_valid", if2.rsp_valid, 1'b1);
    chk16("raw_old_data", if2.rsp_instr, 16'hAAAA);
    step();

    // Second fetch sees the new word; a write during WAIT does not disturb it.
    if2.req_valid = 1'b1;
    if2.req_addr  = 16'h0010;
    step();
    if2.req_valid = 1'b0;
    if2.wr_en     = 1'b1;
    if2.wr_addr   = 16'h0010;
    if2.wr_data   = 16'h6666;
    step();
    if2.wr_en = 1'b0;
    #1;
    chk1("wwait_resp_valid", if2.rsp_valid, 1'b1);
    chk16("wwait_new_data", if2.rsp_instr, 16'h5555);
    step();

    // Reset during WAIT on the LATENCY=3 instance.
    if3.req_valid = 1'b1;
    if3.req_addr  = 16'h0002;
    step();
    if3.req_valid = 1'b0;
    #1;
    chk1("rstw_wait_ready", if3.req_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("rstw_ready", if3.req_ready, 1'b1);
    chk1("rstw_valid", if3.rsp_valid, 1'b0);
    chk16("rstw_instr", if3.rsp_instr, 16'h0000);
    chk1("rstw_fault", if3.rsp_fault, 1'b0);
    step();
    #1;
    chk1("rstw_no_resp_a", if3.rsp_valid, 1'b0);
    step();
    #1;
    chk1("rstw_no_resp_b", if3.rsp_valid, 1'b0);

    // Array survives reset.
    fetch_l2(16'h0010, 16'h6666, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
